// File: rtl/spike_rate_decoder.sv
// Rate decoder for the output layer: counts spikes per class over a window of
// timesteps, then runs a sequential argmax scan and reports the winning class.
module spike_rate_decoder #(
  parameter int N_OUT = 10,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [N_OUT-1:0] spikes,
  input  logic [WIN_W-1:0] window_len,
  output logic [IDX_W-1:0] class_out,
  output logic [CNT_W-1:0] max_count,
  output logic             silent,
  output logic             class_valid,
  output logic             busy
);

  typedef enum logic [1:0] {ACCUM, SCAN, REPORT} state_t;

  state_t           state;
  logic [CNT_W-1:0] counts [N_OUT];
  logic [WIN_W-1:0] step;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] cur_win;
  logic [WIN_W-1:0] last_step;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  // On step 0 the window length is being latched this very edge, so use the
  // live input; a zero length behaves as a one-step window.
  always_comb begin
    cur_win   = (step == '0) ? window_len : win;
    last_step = (cur_win == '0) ? '0 : cur_win - WIN_W'(1);
  end

  always_comb begin
    busy = (state != ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      step        <= '0;
      win         <= '0;
      idx         <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      class_out   <= '0;
      max_count   <= '0;
      silent      <= 1'b0;
      class_valid <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) counts[i] <= '0;
    end else begin
      class_valid <= 1'b0;
      unique case (state)
        ACCUM: begin
          if (ce) begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
              if (spikes[i] && counts[i] != '1) counts[i] <= counts[i] + CNT_W'(1);
            end
            if (step == '0) win <= window_len;
            step <= step + WIN_W'(1);
            if (step == last_step) begin
              state    <= SCAN;
              idx      <= '0;
              best_idx <= '0;
              best_cnt <= '0;
            end
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (counts[idx] > best_cnt) begin
            best_cnt <= counts[idx];
            best_idx <= idx;
          end
          if (idx == IDX_W'(N_OUT - 1)) state <= REPORT;
          else                          idx   <= idx + IDX_W'(1);
        end
        REPORT: begin
          class_out   <= best_idx;
          max_count   <= best_cnt;
          silent      <= (best_cnt == '0);
          class_valid <= 1'b1;
          step        <= '0;
          for (int unsigned i = 0; i < N_OUT; i++) counts[i] <= '0;
          state       <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
